debounce_multi: RTL and testbench

Parametrised multi-channel switch debouncer. Each input bit goes through a 2-flop synchroniser and a per-channel stability counter. Each channel produces a debounced level and single-cycle rising-edge and falling-edge pulses. It sits between the board pushbuttons/switches and the processor control and I/O logic, and replaces the single-channel fixed-depth shift-register debouncer.

---
 rtl/debounce_multi.sv | 139 +++++++++++++
 tb/tb_debounce_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: 2-flop synchroniser, per-channel stability counter, level + edge pulses.
// Define DEBOUNCE_REPEAT_EN to add keyboard-style auto-repeat rise pulses while a channel stays high.
module debounce_multi #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = 10,
    parameter int unsigned REPEAT_DELAY  = 250,
    parameter int unsigned REPEAT_PERIOD = 50
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] d_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_event
);

    if (CHANNELS < 1 || STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("debounce_multi: all parameters must be >= 1");
    end

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] toggle, rise_edge;
    logic                any_q, any_d;
    logic [CntW-1:0]     cnt_q [CHANNELS];
    logic [CntW-1:0]     cnt_d [CHANNELS];

    // Counter only advances while the synchronised input disagrees with the level.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                cnt_d[i]  = '0;
                toggle[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_comb begin
        level_d   = level_q ^ toggle;
        rise_edge = toggle & ~level_q;
        fall_d    = toggle & level_q;
        any_d     = |(rise_q | fall_q);
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;
    localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);

    logic [RepW-1:0]     rep_cnt_q [CHANNELS];
    logic [RepW-1:0]     rep_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] rep_first_q, rep_first_d;
    logic [CHANNELS-1:0] rep_fire;

    // rep_first selects the initial delay until the first repeat has fired.
    always_comb begin
        rep_fire    = '0;
        rep_first_d = rep_first_q;
        for (int i = 0; i < CHANNELS; i++) begin
            rep_cnt_d[i] = rep_cnt_q[i];
            if (rise_edge[i]) begin
                rep_cnt_d[i]   = '0;
                rep_first_d[i] = 1'b1;
            end else if (!level_q[i] || toggle[i]) begin
                rep_cnt_d[i]   = '0;
                rep_first_d[i] = 1'b0;
            end else if (rep_cnt_q[i] == (rep_first_q[i] ? RepDelayLast : RepPeriodLast)) begin
                rep_cnt_d[i]   = '0;
                rep_first_d[i] = 1'b0;
                rep_fire[i]    = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
            end
        end
        rise_d = rise_edge | rep_fire;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rep_first_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            rep_first_q <= rep_first_d;
            for (int i = 0; i < CHANNELS; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end
`else
    always_comb begin
        rise_d = rise_edge;
    end
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= d_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_event  = any_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random stimulus against a
// window-based reference model. Auto-repeat expectations follow DEBOUNCE_REPEAT_EN.
module tb_debounce_multi;

    localparam int CH = 4;
    localparam int S  = 4;
    localparam int D  = 10;
    localparam int P  = 3;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit RepEn = 1'b1;
`else
    localparam bit RepEn = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          reset;
    logic [CH-1:0] d_in;
    logic [CH-1:0] level_out, rise_pulse, fall_pulse;
    logic          any_event;

    int n_checks = 0;
    int n_pass   = 0;

    debounce_multi #(
        .CHANNELS     (CH),
        .STABLE_CYCLES(S),
        .REPEAT_DELAY (D),
        .REPEAT_PERIOD(P)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .d_in      (d_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_event (any_event)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: a channel toggles at edge n when the S synchronised samples it has
    // seen since its last toggle all differ from its level (sync2 before edge n = d at edge n-2).
    logic [CH-1:0] hist [8192];
    int            m_edge;
    int            m_last_tog [CH];
    int            m_rise_t [CH];
    logic [CH-1:0] m_level, m_rise, m_fall;
    logic          m_any;

    function automatic logic samp(input int j, input int ch);
        if (j < 0) return 1'b0;
        return hist[j % 8192][ch];
    endfunction

    always @(posedge clk_in or posedge reset) begin : model
        int            n;
        bit            ok;
        logic [CH-1:0] nr, nf, tg;
        if (reset) begin
            m_edge  <= 0;
            m_level <= '0;
            m_rise  <= '0;
            m_fall  <= '0;
            m_any   <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_last_tog[c] <= -1000;
                m_rise_t[c]   <= -1000;
            end
        end else begin
            n  = m_edge;
            nr = '0;
            nf = '0;
            tg = '0;
            for (int c = 0; c < CH; c++) begin
                ok = (n - m_last_tog[c]) >= S;
                for (int j = n - 1 - S; j <= n - 2; j++) begin
                    if (samp(j, c) == m_level[c]) ok = 1'b0;
                end
                if (ok) begin
                    tg[c]         = 1'b1;
                    m_last_tog[c] <= n;
                    if (!m_level[c]) begin
                        nr[c]       = 1'b1;
                        m_rise_t[c] <= n;
                    end else begin
                        nf[c] = 1'b1;
                    end
                end else if (RepEn && m_level[c] && (n - m_rise_t[c]) >= D &&
                             ((n - m_rise_t[c] - D) % P) == 0) begin
                    nr[c] = 1'b1;
                end
            end
            hist[n % 8192] <= d_in;
            m_any   <= |(m_rise | m_fall);
            m_rise  <= nr;
            m_fall  <= nf;
            m_level <= m_level ^ tg;
            m_edge  <= n + 1;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        d_in  = '0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d_in  = '0;
        #1;
        n_checks++;
        if ({level_out, rise_pulse, fall_pulse, any_event} !== '0)
            $display("FAIL reset_assert: got %b/%b/%b/%b want all 0",
                     level_out, rise_pulse, fall_pulse, any_event);
        else n_pass++;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_in);
            #1;
            n_checks++;
            if ({level_out, rise_pulse, fall_pulse, any_event} !== '0)
                $display("FAIL reset_idle k=%0d: got %b/%b/%b/%b want all 0",
                         k, level_out, rise_pulse, fall_pulse, any_event);
            else n_pass++;
        end
    endtask

    task automatic test_single_edge();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (k == 0) d_in[0] = 1'b1;
            if (k == 10) d_in[0] = 1'b0;
            @(posedge clk_in);
            #1;
            n_checks++;
            if (rise_pulse[0] !== (k == 5) || fall_pulse[0] !== (k == 15) ||
                level_out[0] !== (k >= 5 && k < 15) || any_event !== (k == 6 || k == 16))
                $display("FAIL single_edge k=%0d: got lvl=%b rise=%b fall=%b any=%b", k,
                         level_out[0], rise_pulse[0], fall_pulse[0], any_event);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'b1110_1101;  // applied LSB first: 1,0,1,1,0,1,1,1
        do_reset();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_in);
            d_in[1] = (k < 8) ? pat[k] : 1'b1;
            @(posedge clk_in);
            #1;
            n_checks++;
            if (rise_pulse[1] !== (k == 10) || level_out[1] !== (k >= 10) || fall_pulse[1] !== 1'b0)
                $display("FAIL bounce k=%0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b", k,
                         level_out[1], rise_pulse[1], fall_pulse[1], k >= 10, k == 10);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (k == 0) d_in[3:2] = 2'b11;
            @(posedge clk_in);
            #1;
            n_checks++;
            if (rise_pulse !== ((k == 5) ? 4'b1100 : 4'b0000) || any_event !== (k == 6))
                $display("FAIL simultaneous k=%0d: got rise=%b any=%b", k, rise_pulse, any_event);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            if (k == 0) d_in[0] = 1'b1;
            @(posedge clk_in);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({level_out, rise_pulse, fall_pulse, any_event} !== '0)
            $display("FAIL reset_mid_assert: got %b/%b/%b/%b want all 0",
                     level_out, rise_pulse, fall_pulse, any_event);
        else n_pass++;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_in);
            #1;
            n_checks++;
            if (rise_pulse[0] !== (k == 5) || level_out[0] !== (k >= 5))
                $display("FAIL reset_mid k=%0d: got lvl=%b rise=%b want lvl=%b rise=%b", k,
                         level_out[0], rise_pulse[0], k >= 5, k == 5);
            else n_pass++;
        end
    endtask

    // Release sampled at k=22, so the fall lands on k=27, which is also a repeat slot.
    task automatic test_repeat();
        logic exp_rise;
        do_reset();
        for (int k = 0; k < 36; k++) begin
            @(negedge clk_in);
            if (k == 0) d_in[0] = 1'b1;
            if (k == 22) d_in[0] = 1'b0;
            @(posedge clk_in);
            #1;
            exp_rise = (k == 5) || (RepEn && k >= 15 && k < 27 && ((k - 15) % P) == 0);
            n_checks++;
            if (rise_pulse[0] !== exp_rise || fall_pulse[0] !== (k == 27))
                $display("FAIL repeat k=%0d: got rise=%b fall=%b want rise=%b fall=%b", k,
                         rise_pulse[0], fall_pulse[0], exp_rise, k == 27);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int flip_mod;
        do_reset();
        for (int k = 0; k < 1600; k++) begin
            flip_mod = (k < 900) ? 6 : 40;
            @(negedge clk_in);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(flip_mod - 1) == 0) d_in[c] = ~d_in[c];
            end
            @(posedge clk_in);
            #1;
            n_checks++;
            if ({level_out, rise_pulse, fall_pulse, any_event} !== {m_level, m_rise, m_fall, m_any})
                $display("FAIL random k=%0d: got lvl=%b rise=%b fall=%b any=%b want %b %b %b %b",
                         k, level_out, rise_pulse, fall_pulse, any_event,
                         m_level, m_rise, m_fall, m_any);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        d_in  = '0;
        test_reset();
        test_single_edge();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_repeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
